// File: rtl/ram_port_scheduler.sv
// Round-robin scheduler sharing both ports of a 16x8 dual-port RAM among NUM_REQ requesters.
// Grants up to two accesses per cycle; a same-address write pair drops the port-B grant.
module ram_port_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ*DATA_WIDTH-1:0]  rdata,
    output logic [NUM_REQ-1:0]             rvalid,
    output logic                           write_enable_A,
    output logic                           write_enable_B,
    output logic [7:0]                     address_A,
    output logic [7:0]                     address_B,
    output logic [DATA_WIDTH-1:0]          data_in_A,
    output logic [DATA_WIDTH-1:0]          data_in_B,
    input  logic [DATA_WIDTH-1:0]          data_out_A,
    input  logic [DATA_WIDTH-1:0]          data_out_B,
    output logic [15:0]                    collision_count
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    typedef logic [PW-1:0] idx_t;

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    idx_t                                 rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [NUM_REQ-1:0]                   rvalid_q, rvalid_d;
    logic [15:0]                          coll_cnt_q, coll_cnt_d;

    idx_t idx_a, idx_b, pos;
    logic found_a, found_b, collision, gnt_a, gnt_b;

    function automatic idx_t wrap_inc(input idx_t x);
        if (int'(x) == NUM_REQ - 1) return '0;
        return x + idx_t'(1);
    endfunction

    // One pass around the ring from rr_ptr: first hit takes A, second takes B.
    always_comb begin
        found_a = 1'b0;
        found_b = 1'b0;
        idx_a   = '0;
        idx_b   = '0;
        pos     = rr_ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req[pos]) begin
                if (!found_a) begin
                    found_a = 1'b1;
                    idx_a   = pos;
                end else if (!found_b) begin
                    found_b = 1'b1;
                    idx_b   = pos;
                end
            end
            pos = wrap_inc(pos);
        end
        collision = found_a && found_b && req_we[idx_a] && req_we[idx_b]
                    && (addr_arr[idx_a] == addr_arr[idx_b]);
        gnt_a = found_a && reset_n;
        gnt_b = found_b && !collision && reset_n;
    end

    always_comb begin
        gnt = '0;
        if (gnt_a) gnt[idx_a] = 1'b1;
        if (gnt_b) gnt[idx_b] = 1'b1;
        write_enable_A = gnt_a && req_we[idx_a];
        write_enable_B = gnt_b && req_we[idx_b];
        address_A      = gnt_a ? 8'(addr_arr[idx_a]) : 8'h00;
        address_B      = gnt_b ? 8'(addr_arr[idx_b]) : 8'h00;
        data_in_A      = write_enable_A ? wdata_arr[idx_a] : '0;
        data_in_B      = write_enable_B ? wdata_arr[idx_b] : '0;
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_b)      rr_ptr_d = wrap_inc(idx_b);
        else if (gnt_a) rr_ptr_d = wrap_inc(idx_a);

        rdata_d  = rdata_q;
        rvalid_d = '0;
        if (gnt_a && !req_we[idx_a]) begin
            rdata_d[idx_a]  = data_out_A;
            rvalid_d[idx_a] = 1'b1;
        end
        if (gnt_b && !req_we[idx_b]) begin
            rdata_d[idx_b]  = data_out_B;
            rvalid_d[idx_b] = 1'b1;
        end

        coll_cnt_d = coll_cnt_q;
        if (collision && gnt_a && (coll_cnt_q != 16'hFFFF)) coll_cnt_d = coll_cnt_q + 16'd1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q   <= '0;
            rdata_q    <= '0;
            rvalid_q   <= '0;
            coll_cnt_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            coll_cnt_q <= coll_cnt_d;
        end
    end

    assign rdata           = rdata_q;
    assign rvalid          = rvalid_q;
    assign collision_count = coll_cnt_q;

endmodule

// File: tb/tb_ram_port_scheduler.sv
// Bench for ram_port_scheduler: behavioural RAM, list-based arbitration model, directed + random stimulus.
module tb_ram_port_scheduler;

    localparam int N  = 4;
    localparam int AW = 4;
    localparam int DW = 8;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic [N-1:0]    req = '0, req_we = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    gnt, rvalid;
    logic [N*DW-1:0] rdata;
    logic            write_enable_A, write_enable_B;
    logic [7:0]      address_A, address_B;
    logic [DW-1:0]   data_in_A, data_in_B, data_out_A, data_out_B;
    logic [15:0]     collision_count;

    ram_port_scheduler #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rdata(rdata),
        .rvalid(rvalid), .write_enable_A(write_enable_A), .write_enable_B(write_enable_B),
        .address_A(address_A), .address_B(address_B), .data_in_A(data_in_A),
        .data_in_B(data_in_B), .data_out_A(data_out_A), .data_out_B(data_out_B),
        .collision_count(collision_count)
    );

    // 16x8 RAM: combinational read, write at the rising edge
    logic [7:0] ram [16];
    assign data_out_A = ram[address_A[3:0]];
    assign data_out_B = ram[address_B[3:0]];
    always @(posedge clock) begin
        if (write_enable_A) ram[address_A[3:0]] <= data_in_A;
        if (write_enable_B) ram[address_B[3:0]] <= data_in_B;
    end

    // reference state
    int              m_ptr;
    logic [7:0]      m_mem [16];
    logic [N*DW-1:0] m_rdata;
    logic [N-1:0]    m_rvalid;
    int              m_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int addr_of(input int i);
        return int'(req_addr[i*AW +: AW]);
    endfunction

    function automatic logic [7:0] wd_of(input int i);
        return req_wdata[i*DW +: DW];
    endfunction

    // Called at posedge+1; checks combinational grants mid-cycle and registered results after the edge.
    task automatic step(input bit do_chk);
        int lst[$];
        int a, b;
        bit ha, hb, coll;
        logic [N-1:0] eg;
        for (int k = 0; k < N; k++) if (req[(m_ptr + k) % N]) lst.push_back((m_ptr + k) % N);
        ha = lst.size() > 0;
        hb = lst.size() > 1;
        a  = ha ? lst[0] : 0;
        b  = hb ? lst[1] : 0;
        coll = ha && hb && req_we[a] && req_we[b] && (addr_of(a) == addr_of(b));
        if (coll) hb = 1'b0;
        eg = '0;
        if (ha) eg[a] = 1'b1;
        if (hb) eg[b] = 1'b1;
        #3;
        if (do_chk) begin
            chk("gnt", 32'(gnt), 32'(eg));
            chk("we_a", 32'(write_enable_A), 32'(ha && req_we[a]));
            chk("we_b", 32'(write_enable_B), 32'(hb && req_we[b]));
            chk("addr_a", 32'(address_A), ha ? 32'(addr_of(a)) : 32'd0);
            chk("addr_b", 32'(address_B), hb ? 32'(addr_of(b)) : 32'd0);
            if (ha && req_we[a]) chk("din_a", 32'(data_in_A), 32'(wd_of(a)));
            if (hb && req_we[b]) chk("din_b", 32'(data_in_B), 32'(wd_of(b)));
        end
        m_rvalid = '0;
        if (ha && !req_we[a]) begin m_rdata[a*DW +: DW] = m_mem[addr_of(a)]; m_rvalid[a] = 1'b1; end
        if (hb && !req_we[b]) begin m_rdata[b*DW +: DW] = m_mem[addr_of(b)]; m_rvalid[b] = 1'b1; end
        if (ha && req_we[a]) m_mem[addr_of(a)] = wd_of(a);
        if (hb && req_we[b]) m_mem[addr_of(b)] = wd_of(b);
        if (coll && m_cnt < 65535) m_cnt++;
        if (hb)      m_ptr = (b + 1) % N;
        else if (ha) m_ptr = (a + 1) % N;
        @(posedge clock);
        #1;
        if (do_chk) begin
            chk("rvalid", 32'(rvalid), 32'(m_rvalid));
            chk("rdata", rdata, m_rdata);
            chk("coll_cnt", 32'(collision_count), m_cnt);
            if (ha && req_we[a]) chk("mem_a", 32'(ram[addr_of(a)]), 32'(m_mem[addr_of(a)]));
            if (hb && req_we[b]) chk("mem_b", 32'(ram[addr_of(b)]), 32'(m_mem[addr_of(b)]));
        end
    endtask

    task automatic set_req(input int i, input bit we, input int addr, input logic [7:0] wd);
        req[i]                = 1'b1;
        req_we[i]             = we;
        req_addr[i*AW +: AW]  = AW'(addr);
        req_wdata[i*DW +: DW] = wd;
    endtask

    // Entered at posedge+1; leaves with reset released at posedge+1.
    task automatic do_reset();
        int bad;
        reset_n = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_we_a", 32'(write_enable_A), 32'd0);
        chk("rst_we_b", 32'(write_enable_B), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_cnt", 32'(collision_count), 32'd0);
        @(posedge clock);
        #1;
        bad = 0;
        for (int i = 0; i < 16; i++) if (ram[i] !== m_mem[i]) bad++;
        chk("rst_no_write", bad, 0);
        chk("rst_rdata", rdata, 0);
        m_ptr = 0; m_rdata = '0; m_rvalid = '0; m_cnt = 0;
        reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            ram[i]   = 8'(i * 7 + 1);
            m_mem[i] = 8'(i * 7 + 1);
        end
        m_ptr = 0; m_rdata = '0; m_rvalid = '0; m_cnt = 0;

        // reset with every requester asking to write
        for (int i = 0; i < N; i++) set_req(i, 1'b1, i, 8'hF0 + 8'(i));
        @(posedge clock);
        #1;
        do_reset();

        // round robin on four readers
        for (int i = 0; i < N; i++) set_req(i, 1'b0, i + 8, 8'h00);
        #3;
        chk("first_pair", 32'(gnt), 32'b0011);
        @(posedge clock);
        #1;
        m_rvalid = 4'b0011;
        m_rdata[0 +: DW] = m_mem[8];
        m_rdata[DW +: DW] = m_mem[9];
        m_ptr = 2;
        chk("first_rvalid", 32'(rvalid), 32'b0011);
        for (int c = 0; c < 3; c++) step(1'b1);

        // write-write collision on address 5
        req = '0;
        set_req(0, 1'b1, 5, 8'hAA);
        set_req(1, 1'b1, 5, 8'h55);
        step(1'b1);
        chk("coll_mem_aa", 32'(ram[5]), 32'hAA);
        req[0] = 1'b0;
        step(1'b1);
        chk("coll_mem_55", 32'(ram[5]), 32'h55);

        // read during write on address 3
        req = '0;
        set_req(0, 1'b1, 3, 8'h11);
        step(1'b1);
        set_req(0, 1'b1, 3, 8'h22);
        set_req(1, 1'b0, 3, 8'h00);
        step(1'b1);
        chk("rdw_old", 32'(rdata[DW +: DW]), 32'h11);
        req = '0;
        set_req(1, 1'b0, 3, 8'h00);
        step(1'b1);
        chk("rdw_new", 32'(rdata[DW +: DW]), 32'h22);

        // single requester
        req = '0;
        set_req(2, 1'b0, 6, 8'h00);
        for (int c = 0; c < 3; c++) begin
            step(1'b1);
            chk("single_ptr", m_ptr, 3);
        end

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                req[i] = 1'b0;
                if ($urandom_range(0, 3) != 0)
                    set_req(i, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 8'($urandom));
            end
            step(1'b1);
        end

        // reset while a read return is in flight
        req = '0;
        set_req(3, 1'b0, 2, 8'h00);
        step(1'b1);
        req = 4'b1111;
        req_we = 4'b1111;
        do_reset();
        chk("rst_mid_rvalid", 32'(rvalid), 32'd0);
        req = '0;
        set_req(1, 1'b0, 4, 8'h00);
        set_req(3, 1'b0, 5, 8'h00);
        step(1'b1);

        // saturation of the collision counter
        req = '0;
        set_req(0, 1'b1, 7, 8'h3C);
        set_req(1, 1'b1, 7, 8'hC3);
        for (int c = 0; c < 65540; c++) step(1'b0);
        chk("sat_cnt", 32'(collision_count), 32'hFFFF);
        step(1'b1);
        step(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/ram_port_scheduler.md
# ram_port_scheduler

Round-robin scheduler that shares the two ports of the 16×8 dual-port RAM among NUM_REQ requesters. It grants up to two requests per cycle, one on port A and one on port B. When both grants are writes to the same address it withdraws the port-B grant. Read data is registered back to the requester that issued the read. It sits between the requester fabric and the RAM, drives every RAM port signal, and keeps a saturating collision counter for debug.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- ADDR_WIDTH, 4: requester address width. Values are zero-extended to the RAM's 8-bit address.
- DATA_WIDTH, 8: data width. Must match the RAM.

- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request. Held high until granted.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i uses slice i.
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- gnt  out  NUM_REQ  combinational grant. The access completes at the next rising edge.
- rdata  out  NUM_REQ*DATA_WIDTH  registered read data per requester.
- rvalid  out  NUM_REQ  1-cycle pulse: rdata slice is valid.
- write_enable_A, write_enable_B  out  1  to RAM.
- address_A, address_B  out  8  to RAM, equal to {0, ADDR_WIDTH-bit addr}.
- data_in_A, data_in_B  out  DATA_WIDTH  to RAM.
- data_out_A, data_out_B  in  DATA_WIDTH  from RAM (combinational read).
- collision_count  out  16  saturating count of withdrawn port-B grants.

## Operation
- State held in registers:
  - rr_ptr, a $clog2(NUM_REQ)-bit round-robin pointer;
  - rdata, rvalid;
  - collision_count.
- Port A grant:
  - Scan requesters starting at rr_ptr, wrapping modulo NUM_REQ.
  - The first one with req=1 wins; its index is idx_A.
- Port B grant:
  - Continue the scan from idx_A+1, wrapping, and stop before reaching rr_ptr again.
  - The first requester with req=1 wins; its index is idx_B.
  - A requester never receives both ports in the same cycle.
- Collision rule:
  - Applies when both winners are writes with equal addresses.
  - Port B is not granted and write_enable_B=0.
  - collision_count increments by 1 and saturates at 16'hFFFF.
- Read/write to the same address on A and B: both are granted. The read returns the pre-write (old) data, because the RAM read is combinational and the write lands at the edge.
- RAM drive:
  - An ungranted port has write_enable=0, address=0, data_in=0.
  - A granted read port has write_enable=0 and drives the requester's address.
- Read return:
  - At the edge ending a granted read on port X, rdata[idx] <= data_out_X and rvalid[idx] <= 1.
  - Every other rvalid bit returns to 0.
- Pointer update at each edge:
  - Two grants: rr_ptr <= idx_B+1.
  - Only an A grant (including a collision): rr_ptr <= idx_A+1.
  - No grant: rr_ptr unchanged.
  - All pointer arithmetic is modulo NUM_REQ.
- Requester contract: keep req and its operands stable until gnt=1. Dropping req before grant is allowed; the request is then simply lost.

## Timing
- Reset (reset_n=0, asynchronous):
  - rr_ptr=0, rdata=0, rvalid=0, collision_count=0.
  - gnt=0 and write_enable_A/B=0 are forced combinationally while reset_n=0.
- Grant latency: 0 cycles (gnt in the same cycle as req). The write takes effect at that edge.
- Read latency: rvalid and rdata are high/valid exactly 1 cycle after the gnt cycle.
- Throughput: 2 accesses per cycle without collision; 1 access per cycle with a collision.
- Reset asserted mid-operation: an in-flight rvalid is cleared and no RAM write occurs while reset_n=0.
- Reset release: the first grant scan starts from requester 0.

## Test plan
- Reset:
  - Stimulus: assert reset_n=0 with all req=1.
  - Required: gnt=0, write_enable_A=B=0, rvalid=0, collision_count=0.
  - After release with req=4'b1111, the first cycle gives A→0 and B→1.
- Round robin:
  - Stimulus: req=4'b1111 of reads held for 4 cycles.
  - Required grant pairs are (0,1), (2,3), (0,1), (2,3).
  - Each rvalid pulses 1 cycle after its grant.
- Write-write collision:
  - Stimulus: requesters 0 and 1 both write address 5, with data 8'hAA and 8'h55.
  - Cycle 1: only gnt[0]=1, mem[5]=8'hAA, collision_count=1.
  - Next cycle: gnt[1]=1, mem[5]=8'h55.
- Read-during-write:
  - Stimulus: mem[3]=8'h11; requester 0 writes 8'h22 to address 3 while requester 1 reads address 3 in the same cycle.
  - Required: rdata[1]=8'h11. A following read of address 3 returns 8'h22.
- Single requester:
  - Stimulus: only req[2]=1, 3 cycles.
  - Required: gnt[2]=1 on port A every cycle, port B idle, and rr_ptr=3 after each edge.
- Saturation:
  - Stimulus: force 70000 consecutive collisions.
  - Required: collision_count stops at 16'hFFFF.
